// File: rtl/decode_stage.sv
// MIPS32 instruction-decode stage: decode, operand read with write-back bypass,
// load-use hazard detection, branch flush and the halt/drain state machine.
package decode_stage_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    T_RR     = 3'd0,
    T_RM     = 3'd1,
    T_LOAD   = 3'd2,
    T_STORE  = 3'd3,
    T_BRANCH = 3'd4,
    T_HALT   = 3'd5
  } itype_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_e;

  typedef struct packed {
    logic            valid;
    itype_e          itype;
    alu_e            alu_op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   dest;
    logic [XLEN-1:0] npc;
  } id_ex_t;
endpackage

module decode_stage
  import decode_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_id_valid,
  input  logic [XLEN-1:0] if_id_ir,
  input  logic [XLEN-1:0] if_id_npc,
  input  logic            flush,
  output logic [RW-1:0]   src1,
  output logic [RW-1:0]   src2,
  input  logic [XLEN-1:0] rdData1,
  input  logic [XLEN-1:0] rdData2,
  input  logic            wb_wr_en,
  input  logic [RW-1:0]   wb_dest,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            id_ex_valid,
  output logic [2:0]      id_ex_type,
  output logic [2:0]      id_ex_alu_op,
  output logic [XLEN-1:0] id_ex_a,
  output logic [XLEN-1:0] id_ex_b,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [RW-1:0]   id_ex_dest,
  output logic [XLEN-1:0] id_ex_npc,
  output logic            halted,
  output logic            illegal_op
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  localparam logic [1:0] DRAIN_LAST = 2'd2;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  id_ex_t     id_ex_q, id_ex_d;
  logic       halted_q, halted_d;
  logic       illegal_q, illegal_d;

  logic [5:0]    opcode, funct;
  logic [RW-1:0] rs, rt, rd;
  logic          dec_legal, uses_rt;
  itype_e        dec_type;
  alu_e          dec_alu;
  logic [RW-1:0] dec_dest;
  logic          hazard_c;
  id_ex_t        cap_c;

  assign opcode = if_id_ir[31:26];
  assign rs     = if_id_ir[25:21];
  assign rt     = if_id_ir[20:16];
  assign rd     = if_id_ir[15:11];
  assign funct  = if_id_ir[5:0];
  assign src1   = rs;
  assign src2   = rt;

  // r0 is hard-wired zero; otherwise a write landing this cycle wins over the file.
  function automatic logic [XLEN-1:0] read_operand(
    input logic [RW-1:0]   addr,
    input logic [XLEN-1:0] rf_data,
    input logic            wb_en,
    input logic [RW-1:0]   wb_addr,
    input logic [XLEN-1:0] wb_val
  );
    if (addr == '0)                       return '0;
    else if (wb_en && (wb_addr == addr))  return wb_val;
    else                                  return rf_data;
  endfunction

  // Opcode/funct decode.
  always_comb begin
    dec_legal = 1'b1;
    dec_type  = T_RR;
    dec_alu   = ALU_ADD;
    uses_rt   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        case (funct)
          FN_ADD:  dec_alu = ALU_ADD;
          FN_SUB:  dec_alu = ALU_SUB;
          FN_AND:  dec_alu = ALU_AND;
          FN_OR:   dec_alu = ALU_OR;
          FN_SLT:  dec_alu = ALU_SLT;
          default: dec_legal = 1'b0;
        endcase
      end
      OP_ADDI: dec_type = T_RM;
      OP_LW:   dec_type = T_LOAD;
      OP_SW: begin
        dec_type = T_STORE;
        uses_rt  = 1'b1;
      end
      OP_BEQ: begin
        dec_type = T_BRANCH;
        uses_rt  = 1'b1;
      end
      OP_HLT:  dec_type = T_HALT;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    dec_dest = '0;
    if (dec_type == T_RR)                             dec_dest = rd;
    else if ((dec_type == T_RM) || (dec_type == T_LOAD)) dec_dest = rt;
  end

  // A load in EX whose result is needed by the instruction in ID.
  always_comb begin
    hazard_c = 1'b0;
    if (if_id_valid && dec_legal && (dec_type != T_HALT) &&
        id_ex_q.valid && (id_ex_q.itype == T_LOAD) && (id_ex_q.dest != '0)) begin
      hazard_c = (id_ex_q.dest == rs) || (uses_rt && (id_ex_q.dest == rt));
    end
  end

  always_comb begin
    cap_c        = '0;
    cap_c.valid  = 1'b1;
    cap_c.itype  = dec_type;
    cap_c.alu_op = dec_alu;
    cap_c.a      = read_operand(rs, rdData1, wb_wr_en, wb_dest, wb_data);
    cap_c.b      = read_operand(rt, rdData2, wb_wr_en, wb_dest, wb_data);
    cap_c.imm    = {{16{if_id_ir[15]}}, if_id_ir[15:0]};
    cap_c.dest   = dec_dest;
    cap_c.npc    = if_id_npc;
  end

  // Next-state, ID/EX load and stall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_ex_d   = '0;
    illegal_d = illegal_q;
    stall     = 1'b0;
    case (state_q)
      S_RUN: begin
        if (flush) begin
          stall = 1'b0;
        end else if (hazard_c) begin
          stall = 1'b1;
        end else if (if_id_valid) begin
          if (dec_legal) begin
            id_ex_d = cap_c;
            if (dec_type == T_HALT) begin
              state_d = S_DRAIN;
              cnt_d   = '0;
            end
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        stall = 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_HALTED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_HALTED: stall = 1'b1;
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
    if (!rst_n) stall = 1'b0;
    halted_d = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      cnt_q     <= '0;
      id_ex_q   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_ex_q   <= id_ex_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign id_ex_valid  = id_ex_q.valid;
  assign id_ex_type   = id_ex_q.itype;
  assign id_ex_alu_op = id_ex_q.alu_op;
  assign id_ex_a      = id_ex_q.a;
  assign id_ex_b      = id_ex_q.b;
  assign id_ex_imm    = id_ex_q.imm;
  assign id_ex_dest   = id_ex_q.dest;
  assign id_ex_npc    = id_ex_q.npc;
  assign halted       = halted_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a behavioural reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_id_valid = 1'b0;
  logic [31:0] if_id_ir = '0;
  logic [31:0] if_id_npc = '0;
  logic        flush = 1'b0;
  logic [4:0]  src1, src2;
  logic [31:0] rdData1 = '0, rdData2 = '0;
  logic        wb_wr_en = 1'b0;
  logic [4:0]  wb_dest = '0;
  logic [31:0] wb_data = '0;
  logic        stall, id_ex_valid, halted, illegal_op;
  logic [2:0]  id_ex_type, id_ex_alu_op;
  logic [31:0] id_ex_a, id_ex_b, id_ex_imm, id_ex_npc;
  logic [4:0]  id_ex_dest;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .if_id_valid(if_id_valid), .if_id_ir(if_id_ir),
    .if_id_npc(if_id_npc), .flush(flush), .src1(src1), .src2(src2),
    .rdData1(rdData1), .rdData2(rdData2), .wb_wr_en(wb_wr_en), .wb_dest(wb_dest),
    .wb_data(wb_data), .stall(stall), .id_ex_valid(id_ex_valid),
    .id_ex_type(id_ex_type), .id_ex_alu_op(id_ex_alu_op), .id_ex_a(id_ex_a),
    .id_ex_b(id_ex_b), .id_ex_imm(id_ex_imm), .id_ex_dest(id_ex_dest),
    .id_ex_npc(id_ex_npc), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    int          typ;
    int          alu;
    logic [31:0] a, b, imm;
    int          dest;
    logic [31:0] npc;
  } mrec_t;

  mrec_t m_ex;
  int    m_mode;   // 0 running, 1 draining, 2 halted
  int    m_cnt;    // edges spent draining
  bit    m_ill;

  function automatic bit m_decode(input logic [31:0] ir, output int typ, output int alu);
    int op, fn;
    op  = int'(ir[31:26]);
    fn  = int'(ir[5:0]);
    typ = 0;
    alu = 0;
    if (op == 0) begin
      case (fn)
        32: alu = 0;
        34: alu = 1;
        36: alu = 2;
        37: alu = 3;
        42: alu = 4;
        default: return 1'b0;
      endcase
      return 1'b1;
    end
    case (op)
      8:  typ = 1;
      35: typ = 2;
      43: typ = 3;
      4:  typ = 4;
      63: typ = 5;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_opnd(input int addr, input logic [31:0] rf);
    if (addr == 0) return 32'h0;
    if (wb_wr_en && (int'(wb_dest) == addr)) return wb_data;
    return rf;
  endfunction

  function automatic bit m_hazard();
    int typ, alu, rs, rt;
    if (!if_id_valid) return 1'b0;
    if (!m_decode(if_id_ir, typ, alu)) return 1'b0;
    if (typ == 5) return 1'b0;
    if (!(m_ex.v && m_ex.typ == 2 && m_ex.dest != 0)) return 1'b0;
    rs = int'((if_id_ir >> 21) & 32'd31);
    rt = int'((if_id_ir >> 16) & 32'd31);
    if (rs == m_ex.dest) return 1'b1;
    return (typ == 0 || typ == 3 || typ == 4) && (rt == m_ex.dest);
  endfunction

  function automatic bit m_stall();
    if (!rst_n) return 1'b0;
    if (m_mode != 0) return 1'b1;
    return !flush && m_hazard();
  endfunction

  function automatic bit m_capturing(output mrec_t r);
    int typ, alu, rs, rt;
    r = '{default: 0};
    if (m_mode != 0 || flush || !if_id_valid || m_hazard()) return 1'b0;
    if (!m_decode(if_id_ir, typ, alu)) return 1'b0;
    rs    = int'((if_id_ir >> 21) & 32'd31);
    rt    = int'((if_id_ir >> 16) & 32'd31);
    r.v   = 1'b1;
    r.typ = typ;
    r.alu = alu;
    r.a   = m_opnd(rs, rdData1);
    r.b   = m_opnd(rt, rdData2);
    r.imm = (if_id_ir & 32'h8000) != 0 ? (if_id_ir & 32'hFFFF) | 32'hFFFF0000
                                       : (if_id_ir & 32'hFFFF);
    r.dest = (typ == 0) ? int'((if_id_ir >> 11) & 32'd31)
           : (typ == 1 || typ == 2) ? rt : 0;
    r.npc = if_id_npc;
    return 1'b1;
  endfunction

  function automatic mrec_t m_next_ex();
    mrec_t r;
    void'(m_capturing(r));
    return r;
  endfunction

  function automatic int m_next_mode();
    mrec_t r;
    if (m_mode == 0) return (m_capturing(r) && r.typ == 5) ? 1 : 0;
    if (m_mode == 1) return (m_cnt + 1 == 3) ? 2 : 1;
    return 2;
  endfunction

  function automatic int m_next_cnt();
    return (m_mode == 1) ? m_cnt + 1 : 0;
  endfunction

  function automatic bit m_next_ill();
    int typ, alu;
    if (m_ill) return 1'b1;
    return (m_mode == 0) && !flush && if_id_valid && !m_decode(if_id_ir, typ, alu);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex   <= '{default: 0};
      m_mode <= 0;
      m_cnt  <= 0;
      m_ill  <= 1'b0;
    end else begin
      m_ex   <= m_next_ex();
      m_mode <= m_next_mode();
      m_cnt  <= m_next_cnt();
      m_ill  <= m_next_ill();
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.valid", 32'(id_ex_valid), 32'(m_ex.v));
      chk("m.type", 32'(id_ex_type), 32'(m_ex.typ));
      chk("m.alu_op", 32'(id_ex_alu_op), 32'(m_ex.alu));
      chk("m.a", id_ex_a, m_ex.a);
      chk("m.b", id_ex_b, m_ex.b);
      chk("m.imm", id_ex_imm, m_ex.imm);
      chk("m.dest", 32'(id_ex_dest), 32'(m_ex.dest));
      chk("m.npc", id_ex_npc, m_ex.npc);
      chk("m.halted", 32'(halted), 32'(m_mode == 2));
      chk("m.illegal", 32'(illegal_op), 32'(m_ill));
      chk("m.stall", 32'(stall), 32'(m_stall()));
      chk("m.src1", 32'(src1), (if_id_ir >> 21) & 32'd31);
      chk("m.src2", 32'(src2), (if_id_ir >> 16) & 32'd31);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rr(input int rs, input int rt, input int rd, input int fn);
    return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
  endfunction

  function automatic logic [31:0] iw(input int op, input int rs, input int rt, input logic [15:0] imm);
    return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | {16'h0, imm};
  endfunction

  task automatic put(input logic [31:0] ir);
    if_id_valid = 1'b1;
    if_id_ir    = ir;
    if_id_npc   = if_id_npc + 32'd4;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.valid", 32'(id_ex_valid), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.illegal", 32'(illegal_op), 32'd0);
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;

    // ADD r3,r1,r2
    put(rr(1, 2, 3, 32)); rdData1 = 32'd5; rdData2 = 32'd7;
    #1 chk("add.src1", 32'(src1), 32'd1);
    chk("add.src2", 32'(src2), 32'd2);
    tick();
    chk("add.valid", 32'(id_ex_valid), 32'd1);
    chk("add.type", 32'(id_ex_type), 32'd0);
    chk("add.a", id_ex_a, 32'd5);
    chk("add.b", id_ex_b, 32'd7);
    chk("add.dest", 32'(id_ex_dest), 32'd3);

    // write-back bypass, then wb_dest=0 and src1=0 cases
    put(rr(1, 2, 7, 34)); rdData1 = 32'h11; wb_wr_en = 1'b1; wb_dest = 5'd1; wb_data = 32'hAAAA0000;
    tick();
    chk("byp.a", id_ex_a, 32'hAAAA0000);
    chk("byp.alu", 32'(id_ex_alu_op), 32'd1);
    put(rr(1, 2, 8, 36)); wb_dest = 5'd0; wb_data = 32'hFFFF;
    tick();
    chk("byp0.a", id_ex_a, 32'h11);
    put(rr(0, 2, 8, 37)); wb_dest = 5'd0;
    tick();
    chk("src0.a", id_ex_a, 32'h0);
    wb_wr_en = 1'b0; wb_dest = 5'd0; wb_data = '0;

    // LW r4,8(r1) then SUB r5,r4,r2: one bubble
    put(iw(35, 1, 4, 16'd8));
    tick();
    chk("lw.type", 32'(id_ex_type), 32'd2);
    chk("lw.dest", 32'(id_ex_dest), 32'd4);
    put(rr(4, 2, 5, 34));
    #1 chk("lu.stall", 32'(stall), 32'd1);
    tick();
    chk("lu.bubble", 32'(id_ex_valid), 32'd0);
    chk("lu.npc0", id_ex_npc, 32'd0);
    chk("lu.release", 32'(stall), 32'd0);
    tick();
    chk("lu.sub.valid", 32'(id_ex_valid), 32'd1);
    chk("lu.sub.dest", 32'(id_ex_dest), 32'd5);

    // LW r6 then ADDI r6,r0,3: no hazard
    put(iw(35, 1, 6, 16'd0));
    tick();
    put(iw(8, 0, 6, 16'd3));
    #1 chk("addi.nostall", 32'(stall), 32'd0);
    tick();
    chk("addi.imm", id_ex_imm, 32'd3);
    chk("addi.dest", 32'(id_ex_dest), 32'd6);

    // two LW->use pairs back to back (rt-side and rs-side)
    put(iw(35, 1, 2, 16'd4)); tick();
    put(rr(3, 2, 9, 32));     tick(); tick();
    put(iw(35, 1, 3, 16'd4)); tick();
    put(iw(43, 3, 7, 16'd0)); tick(); tick();
    chk("sw.type", 32'(id_ex_type), 32'd3);

    // sign extension, BEQ dest
    put(iw(8, 1, 6, 16'hFFF0)); tick();
    chk("imm.sext", id_ex_imm, 32'hFFFFFFF0);
    put(iw(4, 1, 2, 16'h0010)); tick();
    chk("beq.dest", 32'(id_ex_dest), 32'd0);
    chk("beq.type", 32'(id_ex_type), 32'd4);

    // flush kills ID
    put(rr(1, 2, 3, 32)); flush = 1'b1;
    #1 chk("fl.stall", 32'(stall), 32'd0);
    tick();
    chk("fl.bubble", 32'(id_ex_valid), 32'd0);
    flush = 1'b0;

    // flush during a load-use stall
    put(iw(35, 1, 4, 16'd0)); tick();
    put(rr(4, 2, 5, 42)); flush = 1'b1;
    #1 chk("flu.stall", 32'(stall), 32'd0);
    tick();
    chk("flu.bubble", 32'(id_ex_valid), 32'd0);
    flush = 1'b0;
    tick();
    chk("flu.slt", 32'(id_ex_alu_op), 32'd4);

    // invalid slot with an undecodable word: no illegal_op
    if_id_valid = 1'b0; if_id_ir = 32'hF8000000; tick();
    chk("inv.noill", 32'(illegal_op), 32'd0);
    // undecodable opcode 0x3E, then bad R-type funct
    put(iw(62, 1, 2, 16'd0)); tick();
    chk("ill.bubble", 32'(id_ex_valid), 32'd0);
    chk("ill.set", 32'(illegal_op), 32'd1);
    put(rr(1, 2, 3, 7)); tick();
    put(rr(1, 2, 3, 32)); tick();
    chk("ill.sticky", 32'(illegal_op), 32'd1);

    // HLT captured at edge N, halted after edge N+3; flush ignored while draining
    put(iw(63, 0, 0, 16'd0)); tick();
    chk("hlt.type", 32'(id_ex_type), 32'd5);
    chk("hlt.stall", 32'(stall), 32'd1);
    put(rr(1, 2, 3, 32)); flush = 1'b1;
    tick();
    chk("drn1.halted", 32'(halted), 32'd0);
    flush = 1'b0;
    tick();
    chk("drn2.halted", 32'(halted), 32'd0);
    tick();
    chk("drn3.halted", 32'(halted), 32'd1);
    tick(); tick();
    chk("hlt.held", 32'(halted), 32'd1);
    chk("hlt.bubble", 32'(id_ex_valid), 32'd0);

    // reset mid-DRAIN
    rst_n = 1'b0; #1;
    rst_n = 1'b1;
    put(iw(63, 0, 0, 16'd0)); tick(); tick();
    rst_n = 1'b0;
    #1 chk("rdrn.halted", 32'(halted), 32'd0);
    chk("rdrn.stall", 32'(stall), 32'd0);
    chk("rdrn.valid", 32'(id_ex_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    put(rr(1, 2, 3, 32)); rdData1 = 32'd9;
    #1 chk("rdrn.run", 32'(stall), 32'd0);
    tick();
    chk("rdrn.cap", id_ex_a, 32'd9);
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
